fpu_ieee_packer: RTL

Downstream stage of `fpu`. It takes each result word and status nibble the FPU produces in the team's 32-bit format (1 sign, 6-bit exponent with bias 31, 25-bit fraction with hidden 1) and converts it to IEEE-754 single precision with round-to-nearest-even. The data path is a 2-stage elastic pipeline followed by an output FIFO, with valid/ready on both sides. It sits between `fpu` and the bus/result collector.

---
 rtl/fpu_ieee_packer_if.sv | 29 ++
 rtl/fpu_ieee_packer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fpu_ieee_packer_if.sv
// fpu_ieee_packer_if
// Valid/ready bus between the FPU, the packer and the result collector.
//   in_valid/in_ready/data_in/status_in : FPU result side
//   out_valid/out_ready/ieee_out/flags_out : converted result side
//   count : output FIFO occupancy
// Modports: slave = packer view, master = driver/consumer view.
interface fpu_ieee_packer_if #(
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              data_in;
    logic [3:0]               status_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              ieee_out;
    logic [4:0]               flags_out;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  in_valid, data_in, status_in, out_ready,
        output in_ready, out_valid, ieee_out, flags_out, count
    );

    modport master (
        output in_valid, data_in, status_in, out_ready,
        input  in_ready, out_valid, ieee_out, flags_out, count
    );
endinterface

// File: rtl/fpu_ieee_packer.sv
// fpu_ieee_packer
// Converts FPU results (1 sign, 6-bit exponent bias 31, 25-bit fraction with
// hidden 1) to IEEE-754 single precision with round-to-nearest-even.
// Two-stage elastic pipeline (decode, round/pack) feeding an output FIFO.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : fpu_ieee_packer_if.slave (input handshake, output handshake,
//           ieee_out, flags_out {INVALID_STATUS,OVERFLOW,UNDERFLOW,INEXACT,ZERO},
//           count)
module fpu_ieee_packer #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    fpu_ieee_packer_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    // S1: decoded input
    logic        s1_valid;
    logic        s1_sign;
    logic [5:0]  s1_exp;
    logic [24:0] s1_frac;
    logic        s1_zero;
    logic        s1_ovf;
    logic        s1_unf;
    logic        s1_inx_in;
    logic        s1_inv;

    // S2: packed result
    logic        s2_valid;
    logic [31:0] s2_data;
    logic [4:0]  s2_flags;

    // FIFO
    logic [31:0] mem_data  [DEPTH];
    logic [4:0]  mem_flags [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        stall;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign bus.out_valid = !empty;
    assign bus.ieee_out  = mem_data[rd_ptr[AW-1:0]];
    assign bus.flags_out = mem_flags[rd_ptr[AW-1:0]];
    assign bus.count     = wr_ptr - rd_ptr;

    assign pop   = bus.out_valid && bus.out_ready;
    // A pop in the same cycle frees the slot S2 needs, so a full FIFO only
    // stalls when nothing leaves.
    assign stall = s2_valid && full && !pop;
    assign push  = s2_valid && !stall;
    assign bus.in_ready = !stall && !reset;

    // Round/pack from S1
    logic        round_up;
    logic [23:0] mant_sum;
    logic [7:0]  exp_base;
    logic [7:0]  exp_final;
    logic [31:0] pack_data;
    logic [4:0]  pack_flags;

    always_comb begin
        round_up   = s1_frac[1] && (s1_frac[0] || s1_frac[2]);
        mant_sum   = {1'b0, s1_frac[24:2]} + {23'b0, round_up};
        exp_base   = {2'b00, s1_exp} + 8'd96;
        // Mantissa carry-out leaves the fraction at zero and bumps the exponent;
        // largest result is 160, far from 255.
        exp_final  = exp_base + {7'b0, mant_sum[23]};
        pack_data  = {s1_sign, exp_final, mant_sum[22:0]};
        pack_flags = {s1_inv, 1'b0, s1_unf, s1_frac[1] | s1_frac[0] | s1_inx_in, 1'b0};
        if (s1_zero) begin
            pack_data  = {s1_sign, 31'b0};
            pack_flags = {s1_inv, 1'b0, s1_unf, (s1_frac != 25'd0) | s1_inx_in, 1'b1};
        end else if (s1_ovf) begin
            pack_data  = {s1_sign, 8'hFF, 23'b0};
            pack_flags = {s1_inv, 1'b1, s1_unf, 1'b1, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exp    <= '0;
            s1_frac   <= '0;
            s1_zero   <= 1'b0;
            s1_ovf    <= 1'b0;
            s1_unf    <= 1'b0;
            s1_inx_in <= 1'b0;
            s1_inv    <= 1'b0;
            s2_valid  <= 1'b0;
            s2_data   <= '0;
            s2_flags  <= '0;
        end else if (!stall) begin
            s1_valid  <= bus.in_valid;
            s1_sign   <= bus.data_in[31];
            s1_exp    <= bus.data_in[30:25];
            s1_frac   <= bus.data_in[24:0];
            s1_zero   <= (bus.data_in[30:25] == 6'd0);
            s1_ovf    <= bus.status_in[2];
            s1_unf    <= bus.status_in[1];
            s1_inx_in <= bus.status_in[0];
            s1_inv    <= bus.status_in[3] && bus.status_in[0];
            s2_valid  <= s1_valid;
            s2_data   <= pack_data;
            s2_flags  <= pack_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i]  <= '0;
                mem_flags[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr[AW-1:0]]  <= s2_data;
                mem_flags[wr_ptr[AW-1:0]] <= s2_flags;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule
